// File: rtl/debug_step_controller.sv
// Debug step controller: accepts host halt/run/step/breakpoint commands and runs the
// STOPX / STEP_REQ / STEP_ACK single-step handshake against the instruction phase decoder.
module debug_step_controller #(
    parameter int ADDR_WIDTH    = 16,
    parameter int STEP_WIDTH    = 16,
    parameter int ACK_TIMEOUT   = 64,
    parameter bit START_STOPPED = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [2:0]            CMD_OP,
    input  logic [15:0]           CMD_DATA,
    input  logic                  ABORT,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic                  FETCH,
    input  logic                  STOPPED,
    input  logic                  DEBUG_ACTIVE,
    input  logic                  DEBUG_STEP_ACK,
    output logic                  DEBUG_STOPX,
    output logic                  DEBUG_STEP_REQ,
    output logic [STEP_WIDTH-1:0] STEPS_LEFT,
    output logic                  STEP_DONE,
    output logic                  BREAK_HIT,
    output logic                  ERROR,
    output logic [2:0]            DBG_STATE
);
    // Command handshake: a command is taken on a rising CLK edge where CMD_VALID and
    // CMD_READY are both high; CMD_READY is high only while RUNNING or HALTED.
    typedef enum logic [2:0] {
        S_RUNNING, S_HALTED, S_WAIT_STOP, S_REQ, S_RELEASE, S_FINISH
    } state_t;

    localparam logic [2:0] OP_HALT   = 3'd1;
    localparam logic [2:0] OP_RUN    = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_SET_BP = 3'd4;
    localparam logic [2:0] OP_CLR_BP = 3'd5;
    localparam int     TW          = $clog2(ACK_TIMEOUT + 1);
    localparam state_t RESET_STATE = START_STOPPED ? S_HALTED : S_RUNNING;

    state_t                state, state_n;
    logic                  stopx, stopx_n, req, req_n, done, done_n;
    logic                  brk, brk_n, err, err_n, ready, ready_n;
    logic                  bp_en, bp_en_n, abort_q, abort_n;
    logic [ADDR_WIDTH-1:0] bp_addr, bp_addr_n;
    logic [STEP_WIDTH-1:0] steps, steps_n, step_cnt;
    logic [TW-1:0]         tmo, tmo_n;
    logic                  cmd_fire, bp_hit, timeout, go_finish;

    assign cmd_fire = CMD_VALID && ready;
    assign step_cnt = CMD_DATA[STEP_WIDTH-1:0];
    assign bp_hit   = bp_en && FETCH && (PC == bp_addr);
    assign timeout  = (tmo == TW'(ACK_TIMEOUT - 1));

    always_comb begin
        state_n   = state;
        stopx_n   = stopx;
        req_n     = req;
        steps_n   = steps;
        done_n    = 1'b0;
        brk_n     = brk;
        err_n     = err;
        bp_en_n   = bp_en;
        bp_addr_n = bp_addr;
        abort_n   = abort_q;
        tmo_n     = tmo;
        go_finish = 1'b0;
        case (state)
            S_RUNNING, S_HALTED: begin
                // A breakpoint hit swallows any command presented in the same cycle.
                if (state == S_RUNNING && bp_hit) begin
                    stopx_n = 1'b1;
                    brk_n   = 1'b1;
                    state_n = S_HALTED;
                end else if (cmd_fire) begin
                    case (CMD_OP)
                        OP_HALT: begin
                            stopx_n = 1'b1;
                            state_n = S_HALTED;
                        end
                        OP_RUN: begin
                            stopx_n = 1'b0;
                            brk_n   = 1'b0;
                            err_n   = 1'b0;
                            state_n = S_RUNNING;
                        end
                        OP_STEP: begin
                            stopx_n = 1'b1;
                            if (step_cnt != '0) begin
                                steps_n = step_cnt;
                                state_n = S_WAIT_STOP;
                            end else begin
                                done_n  = 1'b1;
                                state_n = S_HALTED;
                            end
                        end
                        OP_SET_BP: begin
                            bp_addr_n = CMD_DATA[ADDR_WIDTH-1:0];
                            bp_en_n   = 1'b1;
                        end
                        OP_CLR_BP: bp_en_n = 1'b0;
                        default: ;
                    endcase
                end
            end
            S_WAIT_STOP: begin
                if (ABORT) begin
                    go_finish = 1'b1;
                end else if (DEBUG_ACTIVE && STOPPED && !DEBUG_STEP_ACK) begin
                    req_n   = 1'b1;
                    state_n = S_REQ;
                end else if (timeout) begin
                    err_n     = 1'b1;
                    go_finish = 1'b1;
                end
            end
            S_REQ: begin
                if (ABORT) abort_n = 1'b1;
                if (DEBUG_STEP_ACK) begin
                    req_n   = 1'b0;
                    steps_n = (steps != '0) ? steps - STEP_WIDTH'(1) : steps;
                    state_n = S_RELEASE;
                end else if (timeout) begin
                    req_n     = 1'b0;
                    err_n     = 1'b1;
                    go_finish = 1'b1;
                end
            end
            S_RELEASE: begin
                if (ABORT) abort_n = 1'b1;
                if (!DEBUG_STEP_ACK) begin
                    if (steps == '0 || abort_q || ABORT) begin
                        go_finish = 1'b1;
                    end else begin
                        req_n   = 1'b1;
                        state_n = S_REQ;
                    end
                end else if (timeout) begin
                    err_n     = 1'b1;
                    go_finish = 1'b1;
                end
            end
            S_FINISH: state_n = S_HALTED;
            default:  state_n = RESET_STATE;
        endcase
        if (go_finish) begin
            state_n = S_FINISH;
            done_n  = 1'b1;
            steps_n = '0;
            abort_n = 1'b0;
        end
        // The timeout counter restarts on every state entry.
        if (state_n != state) tmo_n = '0;
        else if (state == S_WAIT_STOP || state == S_REQ || state == S_RELEASE) tmo_n = tmo + TW'(1);
        ready_n = (state_n == S_RUNNING) || (state_n == S_HALTED);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= RESET_STATE;
            stopx   <= START_STOPPED;
            req     <= 1'b0;
            steps   <= '0;
            done    <= 1'b0;
            brk     <= 1'b0;
            err     <= 1'b0;
            bp_en   <= 1'b0;
            bp_addr <= '0;
            abort_q <= 1'b0;
            tmo     <= '0;
            ready   <= 1'b1;
        end else begin
            state   <= state_n;
            stopx   <= stopx_n;
            req     <= req_n;
            steps   <= steps_n;
            done    <= done_n;
            brk     <= brk_n;
            err     <= err_n;
            bp_en   <= bp_en_n;
            bp_addr <= bp_addr_n;
            abort_q <= abort_n;
            tmo     <= tmo_n;
            ready   <= ready_n;
        end
    end

    assign CMD_READY      = ready;
    assign DEBUG_STOPX    = stopx;
    assign DEBUG_STEP_REQ = req;
    assign STEPS_LEFT     = steps;
    assign STEP_DONE      = done;
    assign BREAK_HIT      = brk;
    assign ERROR          = err;
    assign DBG_STATE      = state;
endmodule

// File: tb/tb_debug_step_controller.sv
// Bench for debug_step_controller: decoder model plus transaction-level expectations
// (handshake counts, STEPS_LEFT value sequence, flag states) for randomized step runs.
module tb_debug_step_controller;
    localparam int AW = 16, SW = 16, TMO = 64;
    localparam logic [2:0] OP_HALT = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3;
    localparam logic [2:0] OP_SET_BP = 3'd4, OP_CLR_BP = 3'd5;

    logic          CLK, RESETN, CMD_VALID, CMD_READY, ABORT, FETCH;
    logic [2:0]    CMD_OP, dbg_state;
    logic [15:0]   CMD_DATA;
    logic [AW-1:0] PC;
    logic          STOPPED, DEBUG_ACTIVE, DEBUG_STEP_ACK;
    logic          DEBUG_STOPX, DEBUG_STEP_REQ, STEP_DONE, BREAK_HIT, ERROR;
    logic [SW-1:0] STEPS_LEFT;

    debug_step_controller #(.ADDR_WIDTH(AW), .STEP_WIDTH(SW), .ACK_TIMEOUT(TMO), .START_STOPPED(1'b0)) dut (
        .CLK(CLK), .RESETN(RESETN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .ABORT(ABORT), .PC(PC), .FETCH(FETCH),
        .STOPPED(STOPPED), .DEBUG_ACTIVE(DEBUG_ACTIVE), .DEBUG_STEP_ACK(DEBUG_STEP_ACK),
        .DEBUG_STOPX(DEBUG_STOPX), .DEBUG_STEP_REQ(DEBUG_STEP_REQ), .STEPS_LEFT(STEPS_LEFT),
        .STEP_DONE(STEP_DONE), .BREAK_HIT(BREAK_HIT), .ERROR(ERROR), .DBG_STATE(dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    logic [SW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decoder model: stops stop_lat cycles after STOPX, acks ack_lat cycles after REQ.
    int ack_lat = 4, fall_lat = 1, stop_lat = 2, stop_cnt = 0, ack_cnt = 0, fall_cnt = 0;
    bit ack_en = 1'b1;
    always begin
        @(posedge CLK);
        #1;
        if (!RESETN) begin
            STOPPED = 0; DEBUG_ACTIVE = 0; DEBUG_STEP_ACK = 0;
            stop_cnt = 0; ack_cnt = 0; fall_cnt = 0;
        end else begin
            if (DEBUG_STOPX) begin
                if (stop_cnt < stop_lat) stop_cnt++;
                else begin STOPPED = 1; DEBUG_ACTIVE = 1; end
            end else begin
                stop_cnt = 0; STOPPED = 0; DEBUG_ACTIVE = 0;
            end
            if (!DEBUG_STEP_ACK && DEBUG_STEP_REQ && ack_en) begin
                ack_cnt++;
                if (ack_cnt >= ack_lat) begin DEBUG_STEP_ACK = 1; ack_cnt = 0; end
            end else if (DEBUG_STEP_ACK && !DEBUG_STEP_REQ) begin
                fall_cnt++;
                if (fall_cnt >= fall_lat) begin DEBUG_STEP_ACK = 0; fall_cnt = 0; end
            end
        end
    end

    // driver tasks
    task automatic send_cmd(input logic [2:0] op, input logic [15:0] data);
        int n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < 200) begin @(negedge CLK); n++; end
        if (n >= 200) check("cmd_ready_wait", 32'(CMD_READY), 32'd1);
        CMD_VALID = 1; CMD_OP = op; CMD_DATA = data;
        @(negedge CLK);
        CMD_VALID = 0; CMD_OP = 3'd0; CMD_DATA = 16'd0;
    endtask

    // Expected: h = abort index (if inside the run) else n handshakes;
    // STEPS_LEFT walks n, n-1 .. n-h, then 0; exactly one STEP_DONE; STOPX held high.
    task automatic run_steps(input int n, input int abort_at);
        int h, reqs = 0, dones = 0, stopx_low = 0, bad_req = 0, after = -1, cyc = 0;
        logic prev_req;
        logic [SW-1:0] prev_steps;
        h = (abort_at > 0 && abort_at < n) ? abort_at : n;
        exp_q.delete();
        for (int k = 0; k <= h; k++) exp_q.push_back(SW'(n - k));
        if (n - h != 0) exp_q.push_back('0);
        prev_steps = STEPS_LEFT;
        prev_req = DEBUG_STEP_REQ;
        send_cmd(OP_STEP, 16'(n));
        while (cyc < 3000 && after != 0) begin
            ABORT = 0;
            if (DEBUG_STEP_REQ && !prev_req) begin
                reqs++;
                if (!(STOPPED && DEBUG_ACTIVE)) bad_req++;
                if (reqs == abort_at) ABORT = 1;
            end
            if (STEPS_LEFT != prev_steps) begin
                if (exp_q.size() == 0) check("steps_extra", 32'(STEPS_LEFT), 32'(prev_steps));
                else check("steps_seq", 32'(STEPS_LEFT), 32'(exp_q.pop_front()));
            end
            if (!DEBUG_STOPX) stopx_low++;
            if (STEP_DONE) begin dones++; if (after < 0) after = 6; end
            if (after > 0) after--;
            prev_req = DEBUG_STEP_REQ;
            prev_steps = STEPS_LEFT;
            @(negedge CLK);
            cyc++;
        end
        ABORT = 0;
        check("step_run_bound", 32'(after == 0), 32'd1);
        check("step_reqs", 32'(reqs), 32'(h));
        check("step_done_cnt", 32'(dones), 32'd1);
        check("steps_q_left", 32'(exp_q.size()), 32'd0);
        check("stopx_held", 32'(stopx_low), 32'd0);
        check("req_gated", 32'(bad_req), 32'd0);
        check("steps_final", 32'(STEPS_LEFT), 32'd0);
        check("step_err", 32'(ERROR), 32'd0);
        check("step_ready", 32'(CMD_READY), 32'd1);
    endtask

    // Drives PCs with FETCH; expects the stop exactly one cycle after the hit.
    task automatic bp_walk(input logic [AW-1:0] addr, input int hit_idx, input bit cmd_at_hit);
        for (int i = 0; i <= hit_idx; i++) begin
            logic [AW-1:0] pc;
            pc = (i == hit_idx) ? addr : addr - AW'(2 * (hit_idx - i));
            PC = pc; FETCH = 1;
            if (i == hit_idx && cmd_at_hit) begin CMD_VALID = 1; CMD_OP = OP_STEP; CMD_DATA = 16'd5; end
            @(negedge CLK);
            FETCH = 0; CMD_VALID = 0; CMD_OP = 3'd0; CMD_DATA = 16'd0;
            check(i == hit_idx ? "bp_stop" : "bp_early", 32'(DEBUG_STOPX), 32'(i == hit_idx));
        end
        check("bp_flag", 32'(BREAK_HIT), 32'd1);
        check("bp_steps", 32'(STEPS_LEFT), 32'd0);
    endtask

    initial begin
        int n, a, cnt;
        logic [AW-1:0] addr;
        RESETN = 0; CMD_VALID = 0; CMD_OP = 0; CMD_DATA = 0; ABORT = 0; PC = 0; FETCH = 0;
        STOPPED = 0; DEBUG_ACTIVE = 0; DEBUG_STEP_ACK = 0;
        repeat (3) @(negedge CLK);
        RESETN = 1;
        @(negedge CLK);
        check("rst_stopx", 32'(DEBUG_STOPX), 32'd0);
        check("rst_ready", 32'(CMD_READY), 32'd1);
        check("rst_req", 32'(DEBUG_STEP_REQ), 32'd0);
        check("rst_flags", {29'd0, STEP_DONE, BREAK_HIT, ERROR}, 32'd0);
        check("rst_steps", 32'(STEPS_LEFT), 32'd0);

        send_cmd(OP_HALT, 16'd0);
        check("halt_stopx", 32'(DEBUG_STOPX), 32'd1);
        check("halt_ready", 32'(CMD_READY), 32'd1);

        run_steps(3, 0);

        send_cmd(OP_STEP, 16'd0);
        check("step0_done", 32'(STEP_DONE), 32'd1);
        check("step0_stopx", 32'(DEBUG_STOPX), 32'd1);
        @(negedge CLK);
        check("step0_pulse", 32'(STEP_DONE), 32'd0);

        send_cmd(OP_SET_BP, 16'h0040);
        send_cmd(OP_RUN, 16'd0);
        check("run_stopx", 32'(DEBUG_STOPX), 32'd0);
        bp_walk(16'h0040, 2, 1'b0);
        send_cmd(OP_RUN, 16'd0);
        check("run_clr_brk", 32'(BREAK_HIT), 32'd0);

        addr = AW'($urandom_range(16'h0100, 16'hF000)) & ~AW'(1);
        send_cmd(OP_SET_BP, 16'(addr));
        bp_walk(addr, int'($urandom_range(0, 4)), 1'b1);
        repeat (10) @(negedge CLK);
        check("bp_no_step", 32'(DEBUG_STEP_REQ), 32'd0);
        send_cmd(OP_RUN, 16'd0);
        send_cmd(OP_CLR_BP, 16'd0);
        PC = addr; FETCH = 1;
        @(negedge CLK);
        FETCH = 0;
        @(negedge CLK);
        check("bp_cleared", 32'(DEBUG_STOPX), 32'd0);

        stop_lat = 6;
        run_steps(1, 0);
        stop_lat = 2;
        ack_lat = int'($urandom_range(1, 6));
        run_steps(10, 2);

        for (int it = 0; it < 6; it++) begin
            ack_lat = int'($urandom_range(1, 6));
            fall_lat = int'($urandom_range(1, 3));
            stop_lat = int'($urandom_range(0, 5));
            n = int'($urandom_range(1, 6));
            a = int'($urandom_range(0, n));
            if ($urandom_range(0, 1) == 1) send_cmd(OP_RUN, 16'd0);
            run_steps(n, a);
        end

        ack_en = 0;
        send_cmd(OP_STEP, 16'd2);
        cnt = 0;
        while (!DEBUG_STEP_REQ && cnt < 200) begin @(negedge CLK); cnt++; end
        check("tmo_req_seen", 32'(DEBUG_STEP_REQ), 32'd1);
        cnt = 0;
        while (!ERROR && cnt < 200) begin @(negedge CLK); cnt++; end
        check("tmo_cycles", 32'(cnt), 32'(TMO));
        check("tmo_req_drop", 32'(DEBUG_STEP_REQ), 32'd0);
        check("tmo_done", 32'(STEP_DONE), 32'd1);
        check("tmo_steps", 32'(STEPS_LEFT), 32'd0);
        @(negedge CLK);
        check("tmo_halted", {30'd0, CMD_READY, DEBUG_STOPX}, 32'd3);
        check("tmo_sticky", 32'(ERROR), 32'd1);
        send_cmd(OP_RUN, 16'd0);
        check("run_clr_err", 32'(ERROR), 32'd0);

        send_cmd(OP_STEP, 16'd2);
        cnt = 0;
        while (!DEBUG_STEP_REQ && cnt < 200) begin @(negedge CLK); cnt++; end
        check("rst_mid_req", 32'(DEBUG_STEP_REQ), 32'd1);
        #2 RESETN = 0;
        #1;
        check("async_req", 32'(DEBUG_STEP_REQ), 32'd0);
        check("async_stopx", 32'(DEBUG_STOPX), 32'd0);
        check("async_steps", 32'(STEPS_LEFT), 32'd0);
        check("async_ready", 32'(CMD_READY), 32'd1);
        @(negedge CLK);
        RESETN = 1;
        ack_en = 1;
        repeat (2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/debug_step_controller.md
Name: debug_step_controller

Overview:
- Upstream controller for the instruction phase decoder. Owns DEBUG_STOPX and DEBUG_STEP_REQ, and consumes DEBUG_STEP_ACK, DEBUG_ACTIVE, STOPPED, FETCH.
- Accepts host debug commands (halt, run, N-step, breakpoint set/clear) over a valid/ready interface.
- Runs the full REQ/ACK step handshake per instruction.
- Stops the core on a single PC breakpoint and times out a hung step.

Parameters:
ADDR_WIDTH, 16, PC/breakpoint width
STEP_WIDTH, 16, step-count width
ACK_TIMEOUT, 64, cycles allowed for ACK rise or fall before ERROR
START_STOPPED, 0, reset value of DEBUG_STOPX

Ports:
CLK  in  1  system clock, rising edge
RESETN  in  1  asynchronous active-low reset
CMD_VALID  in  1  command strobe
CMD_READY  out  1  command accepted when CMD_VALID&CMD_READY
CMD_OP  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 SET_BP, 5 CLR_BP, 6/7 NOP
CMD_DATA  in  16  STEP count (low STEP_WIDTH bits) or breakpoint address (low ADDR_WIDTH bits)
ABORT  in  1  cancel an in-progress step sequence
PC  in  ADDR_WIDTH  current program counter
FETCH  in  1  decoder FETCH phase
STOPPED  in  1  decoder STOPPED output
DEBUG_ACTIVE  in  1  decoder debug-mode flag
DEBUG_STEP_ACK  in  1  decoder step acknowledge
DEBUG_STOPX  out  1  stop request to decoder
DEBUG_STEP_REQ  out  1  single-step request
STEPS_LEFT  out  STEP_WIDTH  remaining steps
STEP_DONE  out  1  1-cycle pulse when sequence ends
BREAK_HIT  out  1  sticky, breakpoint caused stop
ERROR  out  1  sticky, handshake timeout

Behaviour:
- Reset (RESETN low, async):
  - State = START_STOPPED ? HALTED : RUNNING; DEBUG_STOPX = START_STOPPED.
  - DEBUG_STEP_REQ=0, STEPS_LEFT=0, STEP_DONE=0, BREAK_HIT=0, ERROR=0, BP_EN=0, BP_ADDR=0, timeout counter=0.
- All outputs are registered. CMD_READY=1 only in RUNNING and HALTED.
- States: RUNNING, HALTED, WAIT_STOP, REQ, RELEASE, FINISH.
- RUNNING (STOPX=0):
  - HALT: STOPX<=1, go to HALTED.
  - STEP N>0: STOPX<=1, STEPS_LEFT<=N, go to WAIT_STOP.
  - STEP N=0: STEP_DONE pulse, STOPX<=1, go to HALTED.
  - RUN: no-op.
  - Breakpoint: if BP_EN && FETCH && PC==BP_ADDR, STOPX<=1, BREAK_HIT<=1, go to HALTED the next cycle. A command accepted in the same cycle is ignored and the breakpoint wins.
- HALTED (STOPX=1):
  - RUN: STOPX<=0, BREAK_HIT<=0, ERROR<=0, go to RUNNING.
  - STEP N>0: STEPS_LEFT<=N, go to WAIT_STOP.
  - STEP N=0: STEP_DONE pulse only.
  - HALT: no-op.
- SET_BP / CLR_BP are accepted in RUNNING or HALTED. SET_BP: BP_ADDR<=CMD_DATA, BP_EN<=1. CLR_BP: BP_EN<=0. Neither changes state.
- WAIT_STOP: wait for DEBUG_ACTIVE&&STOPPED&&!DEBUG_STEP_ACK, then REQ. Breakpoints are ignored in all step states.
- REQ:
  - DEBUG_STEP_REQ=1, held until DEBUG_STEP_ACK=1 is sampled.
  - On ACK: REQ<=0, STEPS_LEFT<=STEPS_LEFT-1, go to RELEASE.
- RELEASE: wait for DEBUG_STEP_ACK=0.
  - Then if STEPS_LEFT==0 or abort is latched, go to FINISH.
  - Else go to REQ. REQ reasserts the cycle after ACK is seen low, so there are at least 2 cycles between ACK fall and the next ACK.
- FINISH: STEP_DONE=1 for one cycle, STEPS_LEFT<=0, go to HALTED. STOPX stays 1.
- ABORT:
  - In WAIT_STOP: go directly to FINISH.
  - In REQ/RELEASE: latch an abort flag. The in-flight step completes its handshake (REQ is never dropped before ACK), then go to FINISH.
  - Ignored in RUNNING/HALTED.
- Timeout:
  - The counter clears on each state entry and increments in WAIT_STOP, REQ and RELEASE.
  - Reaching ACK_TIMEOUT sets ERROR=1 and REQ<=0, then goes to FINISH. STEP_DONE still pulses.
- STEPS_LEFT never wraps: the decrement happens only on ACK with STEPS_LEFT≥1.
- Mid-operation reset: all outputs return to reset values immediately, with no glitch ordering requirement.

Test Plan:
- Reset with START_STOPPED=0, release RESETN → STOPX=0, CMD_READY=1, all flags 0. Then HALT → STOPX=1 next cycle, state HALTED.
- From HALTED, STEP 3, with a decoder model acking 4 cycles after REQ → exactly 3 REQ/ACK pairs, STEPS_LEFT 3→2→1→0, one STEP_DONE pulse, STOPX held 1 throughout.
- SET_BP 0x0040, RUN, PC sequence 0x003C, 0x003E, 0x0040 with FETCH → STOPX=1 the cycle after FETCH@0x0040, BREAK_HIT=1. RUN then clears BREAK_HIT.
- From RUNNING, STEP 1 → STOPX=1. REQ is not raised until DEBUG_ACTIVE&&STOPPED, then one step and STEP_DONE.
- STEP 10 with ABORT pulsed during the 2nd REQ → 2nd handshake completes, STEPS_LEFT forced to 0, STEP_DONE once, no 3rd REQ.
- STEP 2 with the decoder never acking → after 64 cycles ERROR=1, REQ=0, STEP_DONE pulse, state HALTED. Asserting RESETN low mid-REQ drops REQ asynchronously.
